// File: rtl/bus_fifo_pkg.sv
// Shared constants and width helpers for the bus width converting FIFO.
// Port widths of the FIFO and its level controller are derived here.
package bus_fifo_pkg;

  localparam int DEF_RD_WIDTH = 64;
  localparam int DEF_RATIO    = 2;
  localparam int DEF_DEPTH    = 16;

  function automatic int lane_w(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_level_ctrl.sv
// Pointer, level, status flag and sticky error bookkeeping for the
// width converting FIFO; storage lives in the parent.
module fifo_level_ctrl
  import bus_fifo_pkg::*;
#(
  parameter int RATIO    = DEF_RATIO,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - RATIO,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       write_en,
  input  logic [lane_w(RATIO)-1:0]   write_lanes,
  input  logic                       read_en,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic                       wr_accept,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       fifo_half_full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int NW = lane_w(RATIO);
  localparam int LW = level_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic          lanes_ok;
  logic          rd_accept;
  logic [LW-1:0] wr_step;
  logic [LW-1:0] rd_step;

  assign lanes_ok = (write_lanes != '0) &&
                    (write_lanes <= NW'(RATIO));

  // Full leaves room for one whole beat, so acceptance
  // never depends on a same-cycle pop.
  assign fifo_empty     = (level == '0);
  assign fifo_full      = (level > LW'(DEPTH - RATIO));
  assign fifo_half_full = (level >= LW'(DEPTH / 2));
  assign almost_full    = (level >= LW'(AF_LEVEL));
  assign almost_empty   = (level <= LW'(AE_LEVEL));

  assign wr_accept = write_en && !fifo_full &&
                     lanes_ok && !flush;
  assign rd_accept = read_en && !fifo_empty && !flush;

  assign wr_step = wr_accept ? LW'(write_lanes) : '0;
  assign rd_step = rd_accept ? LW'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(wr_step);
      rd_ptr    <= rd_ptr + PW'(rd_accept);
      level     <= level + wr_step - rd_step;
      overflow  <= overflow |
                   (write_en && (fifo_full || !lanes_ok));
      underflow <= underflow | (read_en && fifo_empty);
    end
  end

endmodule

// File: rtl/bus_width_conv_fifo.sv
// Wide-write / narrow-read FIFO: one write beat carries up to RATIO
// read words, stored lane 0 first, read back first-word fall-through.
module bus_width_conv_fifo
  import bus_fifo_pkg::*;
#(
  parameter int RD_WIDTH = DEF_RD_WIDTH,
  parameter int RATIO    = DEF_RATIO,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - RATIO,
  parameter int AE_LEVEL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        write_en,
  input  logic [RATIO*RD_WIDTH-1:0]   write_data,
  input  logic [lane_w(RATIO)-1:0]    write_lanes,
  input  logic                        read_en,
  output logic [RD_WIDTH-1:0]         read_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic                        fifo_half_full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [RD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                wr_accept;

  fifo_level_ctrl #(
    .RATIO    (RATIO),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .write_en       (write_en),
    .write_lanes    (write_lanes),
    .read_en        (read_en),
    .wr_ptr         (wr_ptr),
    .rd_ptr         (rd_ptr),
    .wr_accept      (wr_accept),
    .level          (level),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_half_full (fifo_half_full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  // Lane i lands at wr_ptr+i; the modulo index lets a beat straddle the wrap.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (i < int'(write_lanes)) begin
          mem[wr_ptr + PW'(i)] <=
            write_data[i*RD_WIDTH +: RD_WIDTH];
        end
      end
    end
  end

  assign read_data = mem[rd_ptr];

endmodule

// File: tb/tb_bus_width_conv_fifo.sv
// Scoreboard bench for bus_width_conv_fifo: a queue model of stored
// words and level, directed scenarios followed by random traffic.
module tb_bus_width_conv_fifo;

  localparam int W = 64;
  localparam int R = 2;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           write_en = 1'b0;
  logic [R*W-1:0] write_data = '0;
  logic [1:0]     write_lanes = '0;
  logic           read_en = 1'b0;
  logic [W-1:0]   read_data;
  logic [4:0]     level;
  logic           fifo_empty, fifo_full, fifo_half_full;
  logic           almost_full, almost_empty;
  logic           overflow, underflow;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;
  int           m_level = 0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  string        phase = "reset";

  bus_width_conv_fifo #(
    .RD_WIDTH (W),
    .RATIO    (R),
    .DEPTH    (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .write_en       (write_en),
    .write_data     (write_data),
    .write_lanes    (write_lanes),
    .read_en        (read_en),
    .read_data      (read_data),
    .level          (level),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_half_full (fifo_half_full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  // Monitor: every DUT pop must return the oldest expected word.
  always @(negedge clk) begin
    if (!rst && !flush && read_en && !fifo_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s read_data: got %h, none expected",
                 phase, read_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (read_data !== exp_word) begin
          errors++;
          $display("FAIL %s read_data: got %h want %h",
                   phase, read_data, exp_word);
        end
      end
    end
  end

  task automatic check_status();
    logic [11:0] exp_v;
    logic [11:0] act_v;
    exp_v = {5'(m_level), m_level == 0, m_level > D - R,
             m_level >= D / 2, m_level >= D - R, m_level <= 1,
             m_ovf, m_udf};
    act_v = {level, fifo_empty, fifo_full, fifo_half_full,
             almost_full, almost_empty, overflow, underflow};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s status{lvl,e,f,hf,af,ae,ov,un}: got %b want %b",
               phase, act_v, exp_v);
    end
  endtask

  task automatic expect_val(string name, logic [63:0] act,
                            logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  // One clock: drive at posedge+1, update model after the edge, check.
  task automatic cycle(bit we, logic [R*W-1:0] wd, int lanes,
                       bit re, bit fl);
    bit wacc;
    bit racc;
    int old;
    write_en    = we;
    write_data  = wd;
    write_lanes = 2'(lanes);
    read_en     = re;
    flush       = fl;
    old  = m_level;
    wacc = we && !fl && (old <= D - R) && lanes >= 1 && lanes <= R;
    racc = re && !fl && old > 0;
    if (fl) exp_q.delete();
    if (wacc)
      for (int i = 0; i < lanes; i++) exp_q.push_back(wd[i*W +: W]);
    @(posedge clk);
    #1;
    if (fl) begin
      m_level = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      m_level = old + (wacc ? lanes : 0) - (racc ? 1 : 0);
      if (we && !wacc) m_ovf = 1'b1;
      if (re && old == 0) m_udf = 1'b1;
    end
    check_status();
  endtask

  function automatic logic [R*W-1:0] beat(logic [W-1:0] hi,
                                           logic [W-1:0] lo);
    return {hi, lo};
  endfunction

  task automatic pops(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    #2;
    check_status();
    @(posedge clk);
    #1;
    rst = 1'b0;

    phase = "fill";
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, beat(64'(2*k+1), 64'(2*k)), 2, 1'b0, 1'b0);
      if (k == 3) expect_val("half_after4", 64'(fifo_half_full), 64'd1);
    end
    expect_val("full_after8", 64'(fifo_full), 64'd1);
    pops(16);
    expect_val("empty_after16", 64'(fifo_empty), 64'd1);

    phase = "simul";
    cycle(1'b1, beat(64'd1, 64'd0), 2, 1'b0, 1'b0);
    cycle(1'b1, beat(64'd3, 64'd2), 2, 1'b1, 1'b0);
    expect_val("simul_level3", 64'(level), 64'd3);
    pops(3);

    phase = "partial";
    cycle(1'b1, beat(64'hDEAD, 64'hA), 1, 1'b0, 1'b0);
    cycle(1'b1, beat(64'hC, 64'hB), 2, 1'b0, 1'b0);
    expect_val("partial_level3", 64'(level), 64'd3);
    pops(3);

    phase = "errors";
    for (int k = 0; k < 7; k++)
      cycle(1'b1, beat(64'(100+2*k+1), 64'(100+2*k)), 2, 1'b0, 1'b0);
    cycle(1'b1, beat(64'hFF, 64'd114), 1, 1'b0, 1'b0);
    cycle(1'b1, beat(64'hEE, 64'hEF), 2, 1'b0, 1'b0);
    expect_val("overflow_set", 64'(overflow), 64'd1);
    pops(15);
    cycle(1'b0, '0, 0, 1'b1, 1'b0);
    expect_val("underflow_set", 64'(underflow), 64'd1);
    cycle(1'b0, '0, 0, 1'b0, 1'b1);
    expect_val("flush_level0", 64'(level), 64'd0);
    cycle(1'b1, beat(64'h5, 64'h4), 0, 1'b0, 1'b0);
    expect_val("lanes0_overflow", 64'(overflow), 64'd1);
    cycle(1'b1, beat(64'h5, 64'h4), 3, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, 1'b0, 1'b1);

    phase = "wrap";
    for (int k = 0; k < 7; k++)
      cycle(1'b1, beat(64'(200+2*k+1), 64'(200+2*k)), 2, 1'b0, 1'b0);
    cycle(1'b1, beat(64'hFF, 64'd214), 1, 1'b0, 1'b0);
    pops(15);
    cycle(1'b1, beat(64'h51, 64'h50), 2, 1'b0, 1'b0);
    cycle(1'b1, beat(64'h53, 64'h52), 2, 1'b1, 1'b0);
    pops(3);

    phase = "rst";
    for (int k = 0; k < 3; k++)
      cycle(1'b1, beat(64'(300+2*k+1), 64'(300+2*k)), 2, 1'b0, 1'b0);
    write_en = 1'b0;
    read_en  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_level = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    exp_q.delete();
    check_status();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, beat(64'h21, 64'h20), 2, 1'b0, 1'b0);
    expect_val("first_after_rst", read_data, 64'h20);
    pops(2);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      int ln;
      if ($urandom_range(0, 15) == 0)
        ln = $urandom_range(0, 1) ? 0 : 3;
      else
        ln = $urandom_range(1, 2);
      cycle($urandom_range(0, 9) < 6,
            {$urandom, $urandom, $urandom, $urandom}, ln,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0);
    end

    phase = "drain";
    for (int n = 0; n < 2 * D && m_level > 0; n++) pops(1);
    expect_val("drained_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
